// File: rtl/gpio_axil_if.sv
// AXI4-Lite slave bus bundle for the gpio_axil peripheral.
// Clock and reset are not carried here; they stay plain ports on the peripheral.
interface gpio_axil_if;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/gpio_axil.sv
// AXI4-Lite GPIO peripheral: read-only IDR at 0x00, read/write ODR at 0x04 (aliased every 256 B).
// Define GPIO_IN_SYNC_EN to pass gpio_in through a 2-flop synchronizer before IDR.
module gpio_axil #(
  parameter int unsigned GPIO_WIDTH = 16,
  parameter logic [31:0] ODR_RESET  = 32'h0000_0000
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  gpio_axil_if.slave            axi,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out
);

  typedef enum logic [1:0] {
    REG_IDR,
    REG_ODR,
    REG_NONE
  } reg_sel_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic reg_sel_e decode(input logic [5:0] word_off);
    case (word_off)
      6'h00:   decode = REG_IDR;
      6'h01:   decode = REG_ODR;
      default: decode = REG_NONE;
    endcase
  endfunction

  // Write-side state
  logic [31:0] odr_q, odr_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  // Read-side state
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [GPIO_WIDTH-1:0] gpio_out_q;
  logic [GPIO_WIDTH-1:0] idr_src;
  logic                  wr_accept;
  logic                  rd_accept;
  reg_sel_e              wr_sel;
  reg_sel_e              rd_sel;

  // Only bits [7:2] of each address take part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.s_axi_awaddr[31:8], axi.s_axi_awaddr[1:0],
                              axi.s_axi_araddr[31:8], axi.s_axi_araddr[1:0]};

`ifdef GPIO_IN_SYNC_EN
  logic [GPIO_WIDTH-1:0] sync1_q;
  logic [GPIO_WIDTH-1:0] sync2_q;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  assign idr_src = sync2_q;
`else
  assign idr_src = gpio_in;
`endif

  // Ready is gated by reset so no handshake can complete while reset is held.
  assign wr_accept = !s_axi_areset && axi.s_axi_awvalid && axi.s_axi_wvalid && !bvalid_q;
  assign rd_accept = !s_axi_areset && axi.s_axi_arvalid && !rvalid_q;
  assign wr_sel    = decode(axi.s_axi_awaddr[7:2]);
  assign rd_sel    = decode(axi.s_axi_araddr[7:2]);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    odr_d    = odr_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;

    if (bvalid_q && axi.s_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (wr_accept) begin
      bvalid_d = 1'b1;
      case (wr_sel)
        REG_ODR: begin
          for (int b = 0; b < 4; b++) begin
            if (axi.s_axi_wstrb[b]) begin
              odr_d[8*b +: 8] = axi.s_axi_wdata[8*b +: 8];
            end
          end
          bresp_d = RESP_OKAY;
        end
        REG_IDR: bresp_d = RESP_OKAY;
        default: bresp_d = RESP_SLVERR;
      endcase
    end
  end

  // Read data is taken from odr_q, so a read accepted with an ODR write sees the old value.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;

    if (rvalid_q && axi.s_axi_rready) begin
      rvalid_d = 1'b0;
    end

    if (rd_accept) begin
      rvalid_d = 1'b1;
      case (rd_sel)
        REG_IDR: begin
          rdata_d = 32'(idr_src);
          rresp_d = RESP_OKAY;
        end
        REG_ODR: begin
          rdata_d = odr_q;
          rresp_d = RESP_OKAY;
        end
        default: begin
          rdata_d = 32'h0000_0000;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      odr_q    <= ODR_RESET;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      odr_q    <= odr_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= 32'h0000_0000;
    end else begin
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: the pin register has its own reset value so the pins are defined before the first write.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      gpio_out_q <= ODR_RESET[GPIO_WIDTH-1:0];
    end else begin
      gpio_out_q <= odr_q[GPIO_WIDTH-1:0];
    end
  end

  assign gpio_out          = gpio_out_q;
  assign axi.s_axi_awready = wr_accept;
  assign axi.s_axi_wready  = wr_accept;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = bresp_q;
  assign axi.s_axi_arready = rd_accept;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rresp   = rresp_q;
  assign axi.s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_gpio_axil.sv
// Directed self-checking bench for gpio_axil (default build, GPIO_WIDTH=16, ODR_RESET=0).
module tb_gpio_axil;
  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  gpio_in = '0;
  logic [W-1:0]  gpio_out;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [1:0]    resp;
  logic [31:0]   data;

  gpio_axil_if bus ();

  gpio_axil #(.GPIO_WIDTH(W), .ODR_RESET(32'h0000_0000)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .axi          (bus.slave),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a write at a negedge and hold it until the handshake edge has passed.
  task automatic wr_issue(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb);
    bit ok = 0;
    bus.s_axi_awaddr  = addr;
    bus.s_axi_wdata   = wd;
    bus.s_axi_wstrb   = strb;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.s_axi_awready && bus.s_axi_wready) begin
        ok = 1;
        break;
      end
      @(negedge clk); #1;
    end
    if (ok) @(posedge clk);
    #1;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    if (!ok) check("wr_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_issue(input logic [31:0] addr);
    bit ok = 0;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arvalid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.s_axi_arready) begin
        ok = 1;
        break;
      end
      @(negedge clk); #1;
    end
    if (ok) @(posedge clk);
    #1;
    bus.s_axi_arvalid = 1'b0;
    if (!ok) check("rd_accept_timeout", 32'd0, 32'd1);
  endtask

  // Wait for bvalid, capture bresp, then complete the response handshake.
  task automatic wait_b(output logic [1:0] r);
    bit ok = 0;
    r = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.s_axi_bvalid) begin
        ok = 1;
        r  = bus.s_axi_bresp;
        break;
      end
    end
    if (!ok) check("bvalid_timeout", 32'd0, 32'd1);
    bus.s_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.s_axi_bready = 1'b0;
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
    bit ok = 0;
    d = 'x;
    r = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.s_axi_rvalid) begin
        ok = 1;
        d  = bus.s_axi_rdata;
        r  = bus.s_axi_rresp;
        break;
      end
    end
    if (!ok) check("rvalid_timeout", 32'd0, 32'd1);
    bus.s_axi_rready = 1'b1;
    @(posedge clk); #1;
    bus.s_axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, output logic [1:0] r);
    @(negedge clk);
    wr_issue(addr, wd, strb);
    wait_b(r);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    @(negedge clk);
    rd_issue(addr);
    wait_r(d, r);
  endtask

  initial begin
    bus.s_axi_awaddr  = '0;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata   = '0;
    bus.s_axi_wstrb   = '0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready  = 1'b0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {28'd0, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready, 1'b0}, 32'd0);
    check("rst_valid", {30'd0, bus.s_axi_bvalid, bus.s_axi_rvalid}, 32'd0);
    check("rst_resp",  {28'd0, bus.s_axi_bresp, bus.s_axi_rresp}, 32'd0);
    check("rst_rdata", bus.s_axi_rdata, 32'h0000_0000);
    check("rst_gpio_out", 32'(gpio_out), 32'h0000_0000);
    rst = 1'b0;

    // Full-word ODR write and readback
    axi_write(32'h04, 32'hA5A5_5A5A, 4'hF, resp);
    check("odr_wr_bresp", 32'(resp), 32'h0);
    @(negedge clk);
    check("odr_gpio_out", 32'(gpio_out), 32'h0000_5A5A);
    axi_read(32'h04, data, resp);
    check("odr_rd_data", data, 32'hA5A5_5A5A);
    check("odr_rd_rresp", 32'(resp), 32'h0);

    // IDR sampling
    gpio_in = 16'hABCD;
    repeat (3) @(negedge clk);
    axi_read(32'h00, data, resp);
    check("idr_rd_data", data, 32'h0000_ABCD);
    check("idr_rd_rresp", 32'(resp), 32'h0);

    // Writes to IDR are ignored but acknowledged OKAY
    axi_write(32'h00, 32'h1234_5678, 4'hF, resp);
    check("idr_wr_bresp", 32'(resp), 32'h0);
    axi_read(32'h00, data, resp);
    check("idr_after_wr", data, 32'h0000_ABCD);
    gpio_in = 16'h1234;
    repeat (3) @(negedge clk);
    axi_read(32'h00, data, resp);
    check("idr_new_pins", data, 32'h0000_1234);

    // Byte strobes
    axi_write(32'h04, 32'h0000_FEDC, 4'hF, resp);
    axi_write(32'h04, 32'hFFFF_FF11, 4'h1, resp);
    check("strb_bresp", 32'(resp), 32'h0);
    @(negedge clk);
    check("strb_gpio_out", 32'(gpio_out), 32'h0000_FE11);
    axi_read(32'h04, data, resp);
    check("strb_rd_data", data, 32'h0000_FE11);

    // Unmapped offset
    axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, resp);
    check("unmap_bresp", 32'(resp), 32'h2);
    axi_read(32'h08, data, resp);
    check("unmap_rdata", data, 32'h0);
    check("unmap_rresp", 32'(resp), 32'h2);
    axi_read(32'h04, data, resp);
    check("unmap_odr_kept", data, 32'h0000_FE11);

    // Aliasing: upper and low address bits ignored
    axi_read(32'hFFFF_FF07, data, resp);
    check("alias_rd_data", data, 32'h0000_FE11);

    // Write response stall; gpio_out lags the handshake edge by one cycle
    @(negedge clk);
    wr_issue(32'h04, 32'h0000_0F0F, 4'hF);
    check("gpio_lag_old", 32'(gpio_out), 32'h0000_FE11);
    @(posedge clk); #1;
    check("gpio_lag_new", 32'(gpio_out), 32'h0000_0F0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_stall_valid", {31'd0, bus.s_axi_bvalid}, 32'd1);
    end
    bus.s_axi_awaddr  = 32'h04;
    bus.s_axi_wdata   = 32'h0000_3C3C;
    bus.s_axi_wstrb   = 4'hF;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("b_stall_no_aw", {31'd0, bus.s_axi_awready}, 32'd0);
    end
    bus.s_axi_bready = 1'b1;
    wr_issue(32'h04, 32'h0000_3C3C, 4'hF);
    wait_b(resp);
    check("b_stall_2nd_bresp", 32'(resp), 32'h0);
    @(negedge clk);
    check("b_stall_gpio", 32'(gpio_out), 32'h0000_3C3C);

    // Read response stall
    @(negedge clk);
    rd_issue(32'h04);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("r_stall_valid", {31'd0, bus.s_axi_rvalid}, 32'd1);
      check("r_stall_data", bus.s_axi_rdata, 32'h0000_3C3C);
    end
    wait_r(data, resp);
    @(negedge clk);
    check("r_stall_cleared", {31'd0, bus.s_axi_rvalid}, 32'd0);

    // Simultaneous ODR read and write: the read sees the old value
    @(negedge clk);
    bus.s_axi_awaddr  = 32'h04;
    bus.s_axi_wdata   = 32'h1111_2222;
    bus.s_axi_wstrb   = 4'hF;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    bus.s_axi_araddr  = 32'h04;
    bus.s_axi_arvalid = 1'b1;
    #1;
    check("simul_both_ready", {30'd0, bus.s_axi_awready, bus.s_axi_arready}, 32'd3);
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    wait_b(resp);
    check("simul_bresp", 32'(resp), 32'h0);
    wait_r(data, resp);
    check("simul_rd_old", data, 32'h0000_3C3C);
    axi_read(32'h04, data, resp);
    check("simul_rd_new", data, 32'h1111_2222);

    // Reset in the middle of a read
    @(negedge clk);
    rd_issue(32'h04);
    @(negedge clk);
    check("midrst_rvalid_pre", {31'd0, bus.s_axi_rvalid}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_rvalid", {31'd0, bus.s_axi_rvalid}, 32'd0);
    check("midrst_gpio_out", 32'(gpio_out), 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    axi_read(32'h04, data, resp);
    check("midrst_odr", data, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
